pipe_stage_buf: RTL and testbench
=================================

PIPE_STAGE_BUF -- requirements
Module: pipe_stage_buf

Interface
REQ-001 Parameters SHALL be name, default, meaning: INSTR_W, 32, instruction width.
REQ-002 PC_W, 32, program-counter width.
REQ-003 EXC_W, 5, exception-code width.
REQ-004 NOP_INSTR, 32'h0, instruction value driven when the stage holds a bubble.
REQ-005 RESET_PC, 32'h0000_3000, PC value loaded on reset and flush.
REQ-006 Ports SHALL be: clk  in  1  the only clock, all state on its rising edge.
REQ-007 reset  in  1  synchronous, active-low (reset==0 clears state at the next clk edge).
REQ-008 flush  in  1  discard all held entries (exception/branch kill).
REQ-009 in_valid  in  1  upstream presents a beat.
REQ-010 in_ready  out  1  stage accepts a beat this cycle.
REQ-011 in_instr / in_pc / in_exc / in_bd  in  INSTR_W / PC_W / EXC_W / 1  upstream payload.
REQ-012 out_valid  out  1  stage presents a beat.
REQ-013 out_ready  in  1  downstream accepts this cycle.
REQ-014 out_instr / out_pc / out_exc / out_bd  out  INSTR_W / PC_W / EXC_W / 1  payload.
REQ-015 stall_cnt  out  16  saturating count of cycles with out_valid=1, out_ready=0.

Function
REQ-016 Storage SHALL be two payload entries, main and skid, each with a valid bit; out_* SHALL be driven from main only.
REQ-017 States SHALL be EMPTY (neither valid), ONE (main valid), FULL (main and skid valid); skid valid without main valid is illegal.
REQ-018 Accept = in_valid & in_ready; release = out_valid & out_ready; out_valid = main valid.
REQ-019 in_ready SHALL equal (state != FULL) & ~flush, combinationally.
REQ-020 EMPTY: accept -> ONE, main <= input; no accept -> EMPTY.
REQ-021 ONE: accept & release -> ONE, main <= input; accept only -> FULL, skid <= input; release only -> EMPTY; neither -> hold.
REQ-022 FULL: release -> ONE, main <= skid, skid cleared; no release -> hold.
REQ-023 Latency SHALL be one cycle: a beat accepted at edge N appears on out_* after edge N when main was free or released at N.
REQ-024 Throughput SHALL be one beat per cycle while out_ready=1; no beat is ever duplicated, reordered or dropped except by flush.
REQ-025 While out_valid=1 and out_ready=0, out_* SHALL remain stable.
REQ-026 flush=1 SHALL, at the next edge, force EMPTY regardless of in_valid/out_ready; main payload <= {NOP_INSTR, RESET_PC, 0, 0}; skid cleared.
REQ-027 When EMPTY, out_instr SHALL equal NOP_INSTR, out_exc 0, out_bd 0.
REQ-028 Payload fields SHALL be carried bit-exact; no field width conversion.
REQ-029 stall_cnt SHALL increment by 1 on each edge where out_valid=1 & out_ready=0, saturate at 16'hFFFF, and not be cleared by flush.

Reset
REQ-030 reset==0 at an edge SHALL force EMPTY, main payload {NOP_INSTR, RESET_PC, 0, 0}, skid cleared, stall_cnt 0; reset dominates flush and all handshakes.
REQ-031 Reset asserted mid-transfer SHALL drop all held beats; in_ready SHALL be 1 in the first cycle after reset releases.

Verification
REQ-032 Reset then in_valid=1, in_pc=0x3000, in_instr=0x3C01_0001, out_ready=1 each cycle -> out_pc=0x3000 one cycle later, then one beat per cycle in order.
REQ-033 Fill: out_ready=0, send pc 0x3000, 0x3004 -> after 2 edges FULL, in_ready=0, out_pc=0x3000 held; out_ready=1 -> 0x3000 then 0x3004 emitted, in_ready=1.
REQ-034 Flush in FULL with in_valid=1 -> next cycle out_valid=0, out_instr=NOP_INSTR, out_pc=0x3000, in_ready=1; flushed input beat not emitted.
REQ-035 out_valid=1, out_ready=0 held 70000 cycles -> stall_cnt=0xFFFF, payload unchanged throughout.
REQ-036 in_exc=5'd4, in_bd=1 passed through -> out_exc=4, out_bd=1 on that beat only; bubbles show 0/0.
REQ-037 reset=0 while FULL and stall_cnt=10 -> next cycle EMPTY, stall_cnt=0, out_pc=0x3000.

Source files
------------

// File: rtl/pipe_stage_buf.sv
// Two-entry pipeline stage buffer with a skid slot.
// Keeps full throughput under ready/valid backpressure and counts saturating stall cycles.
module pipe_stage_buf #(
    parameter int                 INSTR_W   = 32,
    parameter int                 PC_W      = 32,
    parameter int                 EXC_W     = 5,
    parameter logic [INSTR_W-1:0] NOP_INSTR = 32'h0,
    parameter logic [PC_W-1:0]    RESET_PC  = 32'h0000_3000
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pc,
    input  logic [EXC_W-1:0]   in_exc,
    input  logic               in_bd,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pc,
    output logic [EXC_W-1:0]   out_exc,
    output logic               out_bd,
    output logic [15:0]        stall_cnt
);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pc;
        logic [EXC_W-1:0]   exc;
        logic               bd;
    } beat_t;

    localparam beat_t BUBBLE = '{
        instr: NOP_INSTR,
        pc:    RESET_PC,
        exc:   {EXC_W{1'b0}},
        bd:    1'b0
    };

    state_e      state_q;
    state_e      state_d;
    beat_t       main_q;
    beat_t       main_d;
    beat_t       skid_q;
    beat_t       skid_d;
    logic [15:0] stall_q;
    logic [15:0] stall_d;

    logic        in_ready_s;
    logic        out_valid_s;
    logic        accept_s;
    logic        release_s;
    logic        stalled_s;
    beat_t       in_beat_s;

    assign in_ready_s  = (state_q != ST_FULL) & ~flush;
    assign out_valid_s = (state_q != ST_EMPTY);
    assign accept_s    = in_valid & in_ready_s;
    assign release_s   = out_valid_s & out_ready;
    assign stalled_s   = out_valid_s & ~out_ready;

    assign in_beat_s = '{instr: in_instr, pc: in_pc, exc: in_exc, bd: in_bd};

    // Next-state and payload steering for the main/skid entries.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = ST_EMPTY;
            main_d  = BUBBLE;
            skid_d  = BUBBLE;
        end else begin
            case (state_q)
                ST_EMPTY: begin
                    if (accept_s) begin
                        state_d = ST_ONE;
                        main_d  = in_beat_s;
                    end else begin
                        state_d = ST_EMPTY;
                    end
                end
                ST_ONE: begin
                    if (accept_s && release_s) begin
                        state_d = ST_ONE;
                        main_d  = in_beat_s;
                    end else if (accept_s) begin
                        state_d = ST_FULL;
                        skid_d  = in_beat_s;
                    end else if (release_s) begin
                        // Drained entry shows a bubble but keeps its last PC.
                        state_d = ST_EMPTY;
                        main_d  = '{instr: NOP_INSTR, pc: main_q.pc,
                                    exc: {EXC_W{1'b0}}, bd: 1'b0};
                    end else begin
                        state_d = ST_ONE;
                    end
                end
                ST_FULL: begin
                    if (release_s) begin
                        state_d = ST_ONE;
                        main_d  = skid_q;
                        skid_d  = BUBBLE;
                    end else begin
                        state_d = ST_FULL;
                    end
                end
                default: begin
                    state_d = ST_EMPTY;
                    main_d  = BUBBLE;
                    skid_d  = BUBBLE;
                end
            endcase
        end
    end

    // Saturating stall counter; flush deliberately leaves it alone.
    always_comb begin
        stall_d = stall_q;
        if (stalled_s && (stall_q != 16'hFFFF)) begin
            stall_d = stall_q + 16'd1;
        end else begin
            stall_d = stall_q;
        end
    end

    // State, payload and counter registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_EMPTY;
            main_q  <= BUBBLE;
            skid_q  <= BUBBLE;
            stall_q <= 16'd0;
        end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            stall_q <= stall_d;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_s;
    assign out_instr = main_q.instr;
    assign out_pc    = main_q.pc;
    assign out_exc   = main_q.exc;
    assign out_bd    = main_q.bd;
    assign stall_cnt = stall_q;

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Directed bench for pipe_stage_buf: streaming, fill/drain, flush, exception fields,
// reset while full and stall-counter saturation.
module tb_pipe_stage_buf;

    logic        clk;
    logic        reset;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  in_exc;
    logic        in_bd;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic [4:0]  out_exc;
    logic        out_bd;
    logic [15:0] stall_cnt;

    int n_checks;
    int n_pass;

    pipe_stage_buf dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_instr  (in_instr),
        .in_pc     (in_pc),
        .in_exc    (in_exc),
        .in_bd     (in_bd),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_instr (out_instr),
        .out_pc    (out_pc),
        .out_exc   (out_exc),
        .out_bd    (out_bd),
        .stall_cnt (stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end else begin
            n_pass++;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] instr,
                         input logic [4:0] exc, input logic bd);
        in_valid = v;
        in_pc    = pc;
        in_instr = instr;
        in_exc   = exc;
        in_bd    = bd;
    endtask

    logic stable_ok;

    initial begin
        n_checks  = 0;
        n_pass    = 0;
        reset     = 1'b0;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        tick();

        check("rst_out_valid", {63'd0, out_valid}, 64'd0);
        check("rst_out_instr", {32'd0, out_instr}, 64'h0);
        check("rst_out_pc",    {32'd0, out_pc},    64'h3000);
        check("rst_out_exc",   {59'd0, out_exc},   64'd0);
        check("rst_out_bd",    {63'd0, out_bd},    64'd0);
        check("rst_stall",     {48'd0, stall_cnt}, 64'd0);
        reset = 1'b1;
        #1;
        check("rst_in_ready",  {63'd0, in_ready},  64'd1);

        // Streaming with downstream always ready.
        out_ready = 1'b1;
        drive(1'b1, 32'h3000, 32'h3C01_0001, 5'd0, 1'b0);
        tick();
        check("str0_valid", {63'd0, out_valid}, 64'd1);
        check("str0_pc",    {32'd0, out_pc},    64'h3000);
        check("str0_instr", {32'd0, out_instr}, 64'h3C01_0001);
        for (int i = 1; i <= 3; i++) begin
            drive(1'b1, 32'h3000 + 32'(4 * i), 32'h3C01_0001 + 32'(i), 5'd0, 1'b0);
            tick();
            check($sformatf("str%0d_pc", i),    {32'd0, out_pc},    64'(32'h3000 + 4 * i));
            check($sformatf("str%0d_instr", i), {32'd0, out_instr}, 64'(32'h3C01_0001 + i));
            check($sformatf("str%0d_rdy", i),   {63'd0, in_ready},  64'd1);
        end
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        check("str_end_valid", {63'd0, out_valid}, 64'd0);
        check("str_end_instr", {32'd0, out_instr}, 64'h0);
        check("str_end_stall", {48'd0, stall_cnt}, 64'd0);

        // Fill both entries with downstream stalled, then drain.
        out_ready = 1'b0;
        drive(1'b1, 32'h3000, 32'hAAAA_0000, 5'd0, 1'b0);
        tick();
        check("fill1_pc",  {32'd0, out_pc},   64'h3000);
        check("fill1_rdy", {63'd0, in_ready}, 64'd1);
        drive(1'b1, 32'h3004, 32'hAAAA_0004, 5'd0, 1'b0);
        tick();
        check("fill2_rdy",   {63'd0, in_ready},  64'd0);
        check("fill2_pc",    {32'd0, out_pc},    64'h3000);
        check("fill2_stall", {48'd0, stall_cnt}, 64'd1);
        drive(1'b1, 32'h3008, 32'hAAAA_0008, 5'd0, 1'b0);
        tick();
        check("fill3_pc",    {32'd0, out_pc},    64'h3000);
        check("fill3_instr", {32'd0, out_instr}, 64'hAAAA_0000);
        check("fill3_stall", {48'd0, stall_cnt}, 64'd2);
        out_ready = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        tick();
        check("drain1_pc",    {32'd0, out_pc},    64'h3004);
        check("drain1_instr", {32'd0, out_instr}, 64'hAAAA_0004);
        check("drain1_rdy",   {63'd0, in_ready},  64'd1);
        check("drain1_stall", {48'd0, stall_cnt}, 64'd2);
        tick();
        check("drain2_valid", {63'd0, out_valid}, 64'd0);

        // Flush while full with a beat offered.
        out_ready = 1'b0;
        drive(1'b1, 32'h4000, 32'hBBBB_0000, 5'd0, 1'b0);
        tick();
        drive(1'b1, 32'h4004, 32'hBBBB_0004, 5'd0, 1'b0);
        tick();
        flush = 1'b1;
        drive(1'b1, 32'h4008, 32'hBBBB_0008, 5'd0, 1'b0);
        #1;
        check("flush_in_ready", {63'd0, in_ready}, 64'd0);
        tick();
        flush = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        #1;
        check("flush_valid", {63'd0, out_valid}, 64'd0);
        check("flush_instr", {32'd0, out_instr}, 64'h0);
        check("flush_pc",    {32'd0, out_pc},    64'h3000);
        check("flush_rdy",   {63'd0, in_ready},  64'd1);
        check("flush_stall", {48'd0, stall_cnt}, 64'd4);
        out_ready = 1'b1;
        tick();
        check("flush_no_emit", {63'd0, out_valid}, 64'd0);

        // Exception code and branch-delay flag pass-through.
        drive(1'b1, 32'h5000, 32'h1111_0000, 5'd0, 1'b0);
        tick();
        check("exc0_exc", {59'd0, out_exc}, 64'd0);
        drive(1'b1, 32'h5004, 32'h1111_0004, 5'd4, 1'b1);
        tick();
        check("exc1_pc",  {32'd0, out_pc},  64'h5004);
        check("exc1_exc", {59'd0, out_exc}, 64'd4);
        check("exc1_bd",  {63'd0, out_bd},  64'd1);
        drive(1'b1, 32'h5008, 32'h1111_0008, 5'd0, 1'b0);
        tick();
        check("exc2_exc", {59'd0, out_exc}, 64'd0);
        check("exc2_bd",  {63'd0, out_bd},  64'd0);
        drive(1'b0, 32'h0, 32'h0, 5'd7, 1'b1);
        tick();
        check("exc_bub_exc", {59'd0, out_exc}, 64'd0);
        check("exc_bub_bd",  {63'd0, out_bd},  64'd0);

        // Reset asserted while full with stall_cnt at 10.
        reset = 1'b0;
        tick();
        reset = 1'b1;
        out_ready = 1'b0;
        drive(1'b1, 32'h7000, 32'hCCCC_0000, 5'd0, 1'b0);
        tick();
        drive(1'b1, 32'h7004, 32'hCCCC_0004, 5'd0, 1'b0);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        for (int i = 0; i < 9; i++) tick();
        check("pre_rst_stall", {48'd0, stall_cnt}, 64'd10);
        check("pre_rst_rdy",   {63'd0, in_ready},  64'd0);
        reset = 1'b0;
        tick();
        reset = 1'b1;
        #1;
        check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
        check("mid_rst_stall", {48'd0, stall_cnt}, 64'd0);
        check("mid_rst_pc",    {32'd0, out_pc},    64'h3000);
        check("mid_rst_rdy",   {63'd0, in_ready},  64'd1);
        out_ready = 1'b1;
        tick();
        check("mid_rst_dropped", {63'd0, out_valid}, 64'd0);

        // Long stall: counter saturation and payload stability.
        out_ready = 1'b0;
        drive(1'b1, 32'h6000, 32'hDEAD_BEEF, 5'd3, 1'b1);
        tick();
        drive(1'b0, 32'h0, 32'h0, 5'd0, 1'b0);
        stable_ok = 1'b1;
        for (int i = 1; i <= 70000; i++) begin
            tick();
            if (out_pc !== 32'h6000 || out_instr !== 32'hDEAD_BEEF ||
                out_exc !== 5'd3 || out_bd !== 1'b1 || out_valid !== 1'b1) begin
                stable_ok = 1'b0;
            end
            if (i == 65534) check("sat_fffe", {48'd0, stall_cnt}, 64'hFFFE);
            if (i == 65535) check("sat_ffff", {48'd0, stall_cnt}, 64'hFFFF);
        end
        check("sat_final",  {48'd0, stall_cnt}, 64'hFFFF);
        check("sat_stable", {63'd0, stable_ok}, 64'd1);
        out_ready = 1'b1;
        tick();
        check("sat_release", {63'd0, out_valid}, 64'd0);
        check("sat_hold",    {48'd0, stall_cnt}, 64'hFFFF);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
